// File: rtl/dmem_resp_pkg.sv
// Shared widths, access-size and FSM state encodings for the dmem_resp
// byte-addressed memory responder.
package dmem_resp_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_WORD   = 2'd0,
    MODE_HALF   = 2'd1,
    MODE_DOUBLE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Bytes touched by one request; the reserved mode never gets this far.
  function automatic logic [3:0] mode_size(input logic [1:0] m);
    case (m)
      MODE_WORD:   return 4'd4;
      MODE_HALF:   return 4'd2;
      MODE_DOUBLE: return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] m);
    case (m)
      MODE_WORD:   return (a[1:0] != 2'b00);
      MODE_HALF:   return a[0];
      MODE_DOUBLE: return (a != 3'b000);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Little-endian byte array with one 4-lane byte-enable write port and a
// combinational 4-byte read port; contents are never reset.
module dmem_array #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [WIDTH-1:0] lane_idx [4];
  logic [3:0]       lane_ok;

  // Lanes past the end of storage read as zero and drop writes.
  always_comb begin
    rdata_o = '0;
    for (int l = 0; l < 4; l++) begin
      lane_idx[l] = addr_i + WIDTH'(l);
      lane_ok[l]  = (lane_idx[l] < WIDTH'(DEPTH_BYTES));
      rdata_o[8*l +: 8] = lane_ok[l] ? mem_q[lane_idx[l][AW-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l] && lane_ok[l]) begin
        mem_q[lane_idx[l][AW-1:0]] <= wdata_i[8*l +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Request/response front end for dmem_array: request checks, latency timer,
// beat sequencing and registered strobes.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency down-counter running
// BEAT0 | first (or only) beat presented/committed
// BEAT1 | second beat of a double access
// ERR   | rejected request, err strobe high
module dmem_resp #(
  parameter int WIDTH       = dmem_resp_pkg::WIDTH,
  parameter int DEPTH_BYTES = 1024,
  parameter int LAT         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add,
  input  logic [1:0]       mode,
  input  logic             rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_st,
  output logic             wr_ack,
  output logic             err,
  output logic             busy
);
  import dmem_resp_pkg::*;

  localparam int EW = WIDTH + 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_q, wdata0_q, wdata1_q;
  logic [1:0]       mode_q;
  logic             wr_q, acc_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rd_st_q, rd_st_d;
  logic             wr_ack_q, wr_ack_d;
  logic             err_q, err_d;

  logic             req, accept, bad_req;
  logic [EW-1:0]    req_end;
  logic [WIDTH-1:0] cur_add, cur_wdata;
  logic [1:0]       cur_mode;
  logic             cur_wr;
  logic             beat_go, beat_sel;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_we;

  assign req     = rd | wr;
  assign accept  = (state_q == ST_IDLE) && req;
  assign req_end = {1'b0, add} + EW'(mode_size(mode));
  assign bad_req = (rd & wr) || (mode == MODE_RSVD) || misaligned(add[2:0], mode) ||
                   (req_end > EW'(DEPTH_BYTES));

  // With LAT=0 the first beat happens on the accept edge, so it must use the
  // live request rather than the captured copy.
  assign cur_add   = (state_q == ST_IDLE) ? add   : add_q;
  assign cur_mode  = (state_q == ST_IDLE) ? mode  : mode_q;
  assign cur_wr    = (state_q == ST_IDLE) ? wr    : wr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? wdata : wdata0_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_go  = 1'b0;
    beat_sel = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (bad_req) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (LAT == 0) begin
            state_d = ST_BEAT0;
            beat_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_BEAT0;
          beat_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_BEAT0: begin
        if (mode_q == MODE_DOUBLE) begin
          state_d  = ST_BEAT1;
          beat_go  = 1'b1;
          beat_sel = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT1: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Beat-1 word arrives one cycle after accept; at LAT=0 that is the same
  // edge that commits it, hence the bypass from the live input.
  always_comb begin
    mem_addr  = cur_add + {{(WIDTH-3){1'b0}}, beat_sel, 2'b00};
    mem_wdata = beat_sel ? (acc_q ? wdata : wdata1_q) : cur_wdata;
    mem_we    = 4'b0000;
    if (beat_go && cur_wr && !rst) begin
      mem_we = (cur_mode == MODE_HALF) ? 4'b0011 : 4'b1111;
    end
    rd_st_d  = beat_go && !cur_wr;
    wr_ack_d = beat_go && cur_wr && (beat_sel || (cur_mode != MODE_DOUBLE));
    rdata_d  = '0;
    if (rd_st_d) begin
      rdata_d = (cur_mode == MODE_HALF) ? {{(WIDTH-16){1'b0}}, mem_rdata[15:0]} : mem_rdata;
    end
  end

  dmem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      rd_st_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= 1'b0;
      add_q    <= '0;
      mode_q   <= MODE_WORD;
      wr_q     <= 1'b0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rd_st_q  <= rd_st_d;
      wr_ack_q <= wr_ack_d;
      err_q    <= err_d;
      acc_q    <= accept;
      if (accept) begin
        add_q    <= add;
        mode_q   <= mode;
        wr_q     <= wr;
        wdata0_q <= wdata;
      end
      if (acc_q) begin
        wdata1_q <= wdata;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rd_st  = rd_st_q;
  assign wr_ack = wr_ack_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a LAT=2 and a LAT=0 instance share one
// request stream; each has its own expected-response queue and monitor.
module tb_dmem_resp;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add;
  logic [1:0]  mode;
  logic        rd, wr;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        rd_st_a, rd_st_b, wr_ack_a, wr_ack_b, err_a, err_b, busy_a, busy_b;

  item_t qa[$];
  item_t qb[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  logic  mon_en = 1'b0;

  dmem_resp #(.WIDTH(32), .DEPTH_BYTES(1024), .LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .add(add), .mode(mode), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata_a), .rd_st(rd_st_a), .wr_ack(wr_ack_a), .err(err_a), .busy(busy_a)
  );

  dmem_resp #(.WIDTH(32), .DEPTH_BYTES(1024), .LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .add(add), .mode(mode), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata_b), .rd_st(rd_st_b), .wr_ack(wr_ack_b), .err(err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic put(input int id, input int kind, input logic [31:0] data, input int c);
    item_t it;
    it.kind = kind;
    it.data = data;
    it.cyc  = c;
    if (id == 0) qa.push_back(it);
    else qb.push_back(it);
  endtask

  // Expected cycle stamps use the cyc value seen #1 after the accept edge.
  task automatic expect_resp(input int id, input int kind, input logic [1:0] m,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input int e, input int lat);
    if (kind == K_ERR) put(id, K_ERR, 32'h0, e);
    else if (m == 2'd2 && kind == K_RD) begin
      put(id, K_RD, e0, e + lat);
      put(id, K_RD, e1, e + lat + 1);
    end else if (m == 2'd2) put(id, K_WR, 32'h0, e + lat + 1);
    else put(id, kind, e0, e + lat);
  endtask

  task automatic mon(input int id, input logic rs, input logic wa, input logic er,
                     input logic [31:0] rdv);
    item_t it;
    int    kind;
    int    qsize;
    string tag;
    tag = (id == 0) ? "a" : "b";
    chk({"excl_", tag}, {31'b0, (rs & wa) | (rs & er) | (wa & er)}, 32'h0);
    if (!rs) chk({"rdata_idle_", tag}, rdv, 32'h0);
    kind = rs ? K_RD : (wa ? K_WR : (er ? K_ERR : -1));
    if (kind >= 0) begin
      qsize = (id == 0) ? qa.size() : qb.size();
      if (qsize == 0) begin
        checks++;
        $display("FAIL unexpected_%s: got kind %0d, want no response (cyc %0d)", tag, kind, cyc);
      end else begin
        if (id == 0) it = qa.pop_front();
        else it = qb.pop_front();
        chk({"kind_", tag}, kind, it.kind);
        chk({"cycle_", tag}, cyc, it.cyc);
        if (kind == K_RD) chk({"rdata_", tag}, rdv, it.data);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) mon(0, rd_st_a, wr_ack_a, err_a, rdata_a);
  always @(negedge clk) if (mon_en) mon(1, rd_st_b, wr_ack_b, err_b, rdata_b);

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy_a && !busy_b) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", {31'b0, busy_a | busy_b}, 32'h0);
  endtask

  task automatic send(input logic r, input logic w, input logic [31:0] a, input logic [1:0] m,
                      input logic [31:0] d0, input logic [31:0] d1, output int e);
    rd = r; wr = w; add = a; mode = m; wdata = d0;
    @(posedge clk); #1;
    e = cyc;
    rd = 1'b0; wr = 1'b0; wdata = d1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [1:0] m,
                       input logic [31:0] d0, input logic [31:0] d1, input int kind,
                       input logic [31:0] e0, input logic [31:0] e1);
    int e;
    send(r, w, a, m, d0, d1, e);
    expect_resp(0, kind, m, e0, e1, e, LAT_A);
    expect_resp(1, kind, m, e0, e1, e, LAT_B);
    wait_idle();
  endtask

  task automatic chk_quiet(input string tag);
    chk({"rst_rdata_a", tag}, rdata_a, 32'h0);
    chk({"rst_flags_a", tag}, {28'b0, rd_st_a, wr_ack_a, err_a, busy_a}, 32'h0);
    chk({"rst_rdata_b", tag}, rdata_b, 32'h0);
    chk({"rst_flags_b", tag}, {28'b0, rd_st_b, wr_ack_b, err_b, busy_b}, 32'h0);
  endtask

  initial begin
    int e;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; add = '0; mode = 2'd0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("_init");
    rst = 1'b0;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0, K_WR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h100, 2'd0, 32'h0, 32'h0, K_RD, 32'hDEADBEEF, 32'h0);
    issue(1'b1, 1'b0, 32'h102, 2'd1, 32'h0, 32'h0, K_RD, 32'h0000DEAD, 32'h0);
    issue(1'b1, 1'b0, 32'h100, 2'd1, 32'h0, 32'h0, K_RD, 32'h0000BEEF, 32'h0);

    issue(1'b0, 1'b1, 32'h104, 2'd0, 32'h00000000, 32'h0, K_WR, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 32'h106, 2'd1, 32'hFFFF5A5A, 32'h0, K_WR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h104, 2'd0, 32'h0, 32'h0, K_RD, 32'h5A5A0000, 32'h0);

    issue(1'b0, 1'b1, 32'h200, 2'd2, 32'h11111111, 32'h22222222, K_WR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h200, 2'd2, 32'h0, 32'h0, K_RD, 32'h11111111, 32'h22222222);

    issue(1'b1, 1'b0, 32'h101, 2'd0, 32'h0, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 32'h100, 2'd0, 32'h12345678, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h3FC, 2'd2, 32'h0, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h100, 2'd3, 32'h0, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 32'h3FF, 2'd1, 32'h0000AAAA, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 32'h400, 2'd0, 32'h55555555, 32'h0, K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h100, 2'd0, 32'h0, 32'h0, K_RD, 32'hDEADBEEF, 32'h0);

    issue(1'b0, 1'b1, 32'h3FC, 2'd0, 32'h0BADF00D, 32'h0, K_WR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h3FC, 2'd0, 32'h0, 32'h0, K_RD, 32'h0BADF00D, 32'h0);

    // Reset in the cycle after accept: the LAT=2 write never lands, while the
    // LAT=0 instance already committed and acked on the accept edge.
    wr = 1'b1; add = 32'h100; mode = 2'd0; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    e = cyc;
    wr = 1'b0; rst = 1'b1;
    put(1, K_WR, 32'h0, e);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_quiet("_abort");
    wait_idle();
    send(1'b1, 1'b0, 32'h100, 2'd0, 32'h0, 32'h0, e);
    put(0, K_RD, 32'hDEADBEEF, e + LAT_A);
    put(1, K_RD, 32'hCAFEF00D, e + LAT_B);
    wait_idle();

    // Read held for three edges: LAT=2 stays busy throughout, LAT=0 frees up
    // after one cycle and takes the request a second time.
    rd = 1'b1; add = 32'h200; mode = 2'd0;
    @(posedge clk); #1;
    e = cyc;
    put(0, K_RD, 32'h11111111, e + 2);
    put(1, K_RD, 32'h11111111, e);
    put(1, K_RD, 32'h11111111, e + 2);
    repeat (2) begin @(posedge clk); #1; end
    rd = 1'b0;
    wait_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 32'h0);
    chk("qb_drained", qb.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024, byte-addressable storage size.
REQ-003 SHALL have parameter LAT, default 2, wait cycles between accept and first response; range 0..15.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-high, rst.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 add  in  WIDTH  request byte address.
REQ-008 mode  in  2  size: 0 word (4B), 1 half (2B), 2 double (8B, two beats), 3 reserved.
REQ-009 rd  in  1  read request.
REQ-010 wr  in  1  write request.
REQ-011 wdata  in  WIDTH  write data; low 16 bits used for half.
REQ-012 rdata  out  WIDTH  read data; valid only while rd_st=1.
REQ-013 rd_st  out  1  read-beat strobe, one cycle per beat.
REQ-014 wr_ack  out  1  write-commit strobe, one cycle.
REQ-015 err  out  1  request-rejected strobe, one cycle.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 Storage SHALL be little-endian, byte-addressed; contents are not cleared by rst.
REQ-018 A request SHALL be accepted at edge T when (rd|wr)=1 and busy=0; add, mode, and wdata (beat 0) are captured then.
REQ-019 States SHALL be IDLE, WAIT, BEAT0, BEAT1, ERR; IDLE->ERR on rejected accept, IDLE->WAIT on valid accept when LAT>0, IDLE->BEAT0 on valid accept when LAT=0.
REQ-020 WAIT SHALL count LAT cycles, then go to BEAT0.
REQ-021 BEAT0 SHALL go to BEAT1 for double, else to IDLE; BEAT1 and ERR SHALL go to IDLE.
REQ-022 First response SHALL be high in cycle T+LAT+1; second beat of a double in cycle T+LAT+2.
REQ-023 Read word: rdata = bytes add..add+3, rd_st=1 in BEAT0.
REQ-024 Read half: rdata = zero-extended bytes add..add+1, rd_st=1 in BEAT0.
REQ-025 Read double: BEAT0 returns bytes add..add+3, BEAT1 returns add+4..add+7, rd_st=1 in both.
REQ-026 Write: bytes are committed at the BEAT0 (or BEAT1) edge, with wr_ack=1 only in the final beat state; a double takes its beat-1 word from wdata sampled at T+1.
REQ-027 Rejected SHALL be: rd&wr both high, mode=3, add misaligned (word add[1:0]!=0, half add[0]!=0, double add[2:0]!=0), or add+size > DEPTH_BYTES.
REQ-028 A rejected request SHALL pulse err in cycle T+1, with no storage access, no rd_st, and no wr_ack.
REQ-029 Requests SHALL be ignored while busy=1; a new request is acceptable in the cycle after the final response (back-to-back spacing is LAT+2 cycles for single-beat accesses).
REQ-030 rd_st, wr_ack, and err SHALL be mutually exclusive and registered.
REQ-031 rdata SHALL hold 0 whenever rd_st=0.

Reset
REQ-032 rst=1 SHALL force state IDLE, counter 0, and rdata, rd_st, wr_ack, err, busy all 0 at the next edge.
REQ-033 rst during WAIT/BEAT0/BEAT1 SHALL abort the access; uncommitted write bytes are not written, and already committed beat-0 bytes of a double remain.
REQ-034 rst has priority over a simultaneous request.

Structure
REQ-035 The shared params file SHALL hold WIDTH, the mode encodings (WORD/HALF/DOUBLE), and the state encodings.
REQ-036 One sub-module, dmem_array, SHALL be used: a byte array with a 4-byte-lane write-enable read/write port; the FSM, counter, and checks stay in dmem_resp.

Verification
REQ-037 LAT=2: write word 0xDEADBEEF @0x100, then read word @0x100 -> wr_ack at T+3; later rd_st at T'+3 with rdata 0xDEADBEEF.
REQ-038 After REQ-037: read half @0x102 -> rdata 0x0000DEAD; read half @0x100 -> rdata 0x0000BEEF.
REQ-039 Write double @0x200 with 0x11111111 at T and 0x22222222 at T+1, then read double -> two consecutive rd_st beats: 0x11111111, then 0x22222222.
REQ-040 Read word @0x101, rd&wr both high @0x100, and read double @0x3FC -> err at T+1 each, no rd_st/wr_ack, memory unchanged.
REQ-041 Write word 0xCAFEF00D @0x100 with rst at T+1 -> no wr_ack; subsequent read @0x100 returns 0xDEADBEEF; all outputs 0 after reset.
REQ-042 Request held high while busy -> exactly one response; LAT=0 build gives rd_st at T+1.
